// File: rtl/tb_dual_port_mem.sv
// Purpose : shared-array simulation memory serving an instruction port and a data port, with a tohost mailbox.
// Latency : IMEM_LATENCY / DMEM_LATENCY edges from request to valid (1 = data visible the cycle after the request).
// Backpressure: none; one request accepted per cycle per port, results are never held or stalled.
//
// Ports:
//   clk, reset_n                 clock and synchronous active-low reset (array contents survive reset)
//   IMEM_addr_i, IMEM_read_n_i   instruction byte address and active-low read request
//   IMEM_data_o, IMEM_valid_o    instruction read data and its valid strobe
//   DMEM_addr_i                  data byte address
//   DMEM_read_i, DMEM_write_i    data read / write requests (write wins)
//   DMEM_be_i, DMEM_data_i       byte enables and lane-positioned write data
//   DMEM_data_o, DMEM_valid_o    data read data and its valid strobe
//   tohost_o, tohost_valid_o     mailbox word and one-cycle write pulse
module tb_dual_port_mem #(
  parameter int          ADDR_WIDTH   = 11,
  parameter int          IMEM_LATENCY = 1,
  parameter int          DMEM_LATENCY = 1,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] IMEM_addr_i,
  input  logic        IMEM_read_n_i,
  output logic [31:0] IMEM_data_o,
  output logic        IMEM_valid_o,
  input  logic [31:0] DMEM_addr_i,
  input  logic        DMEM_read_i,
  input  logic        DMEM_write_i,
  input  logic [3:0]  DMEM_be_i,
  input  logic [31:0] DMEM_data_i,
  output logic [31:0] DMEM_data_o,
  output logic        DMEM_valid_o,
  output logic [31:0] tohost_o,
  output logic        tohost_valid_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (IMEM_LATENCY < 1 || IMEM_LATENCY > 8) begin : g_bad_imem_latency
    $error("tb_dual_port_mem: IMEM_LATENCY must be within 1..8");
  end
  if (DMEM_LATENCY < 1 || DMEM_LATENCY > 8) begin : g_bad_dmem_latency
    $error("tb_dual_port_mem: DMEM_LATENCY must be within 1..8");
  end

  // Shared word array, named 'mem' so a bench can preload it hierarchically.
  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] i_idx;
  logic [ADDR_WIDTH-1:0] d_idx;
  logic                  i_req;
  logic                  d_req;
  logic                  tohost_hit;
  logic [31:0]           tohost_nxt;

  // Address bits above the array and the byte offset are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IMEM_addr_i[31:ADDR_WIDTH+2], IMEM_addr_i[1:0], DMEM_addr_i[1:0]};

  assign i_idx = IMEM_addr_i[ADDR_WIDTH+1:2];
  assign d_idx = DMEM_addr_i[ADDR_WIDTH+1:2];
  assign i_req = !IMEM_read_n_i;
  // A write in the same cycle suppresses the data read entirely.
  assign d_req = DMEM_read_i && !DMEM_write_i;
  // Mailbox decode uses the full address so aliases of the same array word do not fire it.
  assign tohost_hit = DMEM_write_i && (DMEM_addr_i[31:2] == TOHOST_ADDR[31:2]);

  always_comb begin
    tohost_nxt = tohost_o;
    for (int k = 0; k < 4; k++) begin
      if (DMEM_be_i[k]) tohost_nxt[8*k +: 8] = DMEM_data_i[8*k +: 8];
    end
  end

  // Array is never touched by reset so a preload survives it.
  always_ff @(posedge clk) begin
    if (reset_n && DMEM_write_i) begin
      for (int k = 0; k < 4; k++) begin
        if (DMEM_be_i[k]) mem[d_idx][8*k +: 8] <= DMEM_data_i[8*k +: 8];
      end
    end
  end

  // Read pipelines: stage 0 samples the array on the request edge (read-first
  // against a concurrent write); each stage only loads when its input is valid,
  // so the last stage doubles as the hold-last-value output register.
  logic [IMEM_LATENCY-1:0] i_vld;
  logic [31:0]             i_dat [IMEM_LATENCY];
  logic [DMEM_LATENCY-1:0] d_vld;
  logic [31:0]             d_dat [DMEM_LATENCY];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_vld <= '0;
      for (int k = 0; k < IMEM_LATENCY; k++) i_dat[k] <= '0;
    end else begin
      i_vld[0] <= i_req;
      if (i_req) i_dat[0] <= mem[i_idx];
      for (int k = 1; k < IMEM_LATENCY; k++) begin
        i_vld[k] <= i_vld[k-1];
        if (i_vld[k-1]) i_dat[k] <= i_dat[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_vld <= '0;
      for (int k = 0; k < DMEM_LATENCY; k++) d_dat[k] <= '0;
    end else begin
      d_vld[0] <= d_req;
      if (d_req) d_dat[0] <= mem[d_idx];
      for (int k = 1; k < DMEM_LATENCY; k++) begin
        d_vld[k] <= d_vld[k-1];
        if (d_vld[k-1]) d_dat[k] <= d_dat[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tohost_o       <= '0;
      tohost_valid_o <= 1'b0;
    end else begin
      tohost_valid_o <= tohost_hit;
      if (tohost_hit) tohost_o <= tohost_nxt;
    end
  end

  assign IMEM_valid_o = i_vld[IMEM_LATENCY-1];
  assign IMEM_data_o  = i_dat[IMEM_LATENCY-1];
  assign DMEM_valid_o = d_vld[DMEM_LATENCY-1];
  assign DMEM_data_o  = d_dat[DMEM_LATENCY-1];

endmodule

// File: doc/tb_dual_port_mem.md
Name: tb_dual_port_mem

Overview:
Parametrised simulation memory model serving the core's instruction and data buses from one shared word array, loaded by the bench via $readmemh.
Generalises the fixed single-cycle two-port RAM with the following additions:
- configurable per-port read latency;
- per-port read-valid strobes;
- byte-enable writes (SB/SH/SW);
- a tohost mailbox that signals test completion without probing core internals.

Sits in the testbench between top_riscV and the stimulus/checker tasks.

Parameters:
ADDR_WIDTH, 11, word-address bits; array depth 2**ADDR_WIDTH words of 32 bits.
IMEM_LATENCY, 1, cycles from IMEM request edge to IMEM_valid_o; legal 1..8.
DMEM_LATENCY, 1, cycles from DMEM read request edge to DMEM_valid_o; legal 1..8.
TOHOST_ADDR, 32'h0000_1000, byte address of the tohost mailbox word.

Ports:
clk  input  1  clock, all logic on posedge
reset_n  input  1  synchronous, active-low reset
IMEM_addr_i  input  32  instruction byte address
IMEM_read_n_i  input  1  active-low instruction read request
IMEM_data_o  output  32  instruction read data
IMEM_valid_o  output  1  IMEM_data_o valid this cycle
DMEM_addr_i  input  32  data byte address
DMEM_read_i  input  1  data read request
DMEM_write_i  input  1  data write request
DMEM_be_i  input  4  byte enables, bit i -> bits [8i+7:8i]
DMEM_data_i  input  32  write data, byte lanes already positioned
DMEM_data_o  output  32  data read data
DMEM_valid_o  output  1  DMEM_data_o valid this cycle
tohost_o  output  32  last value written to TOHOST_ADDR
tohost_valid_o  output  1  one-cycle pulse on tohost write

Behaviour:
- Reset is sampled on posedge clk only; no asynchronous path.
- While reset_n=0:
  - IMEM_data_o, DMEM_data_o, tohost_o = 0.
  - IMEM_valid_o, DMEM_valid_o, tohost_valid_o = 0.
  - All latency pipeline stages are cleared.
  - Requests are ignored.
  - Array contents are NOT modified, so a preload survives reset.
- Indexing: word index = addr[ADDR_WIDTH+1:2]. Upper bits are ignored (silent wrap-around). addr[1:0] is ignored.
- Read pipeline, per port, depth = port LATENCY:
  - A request sampled at edge n reads the array at edge n.
  - Data and valid are presented at edge n+LATENCY-1. LATENCY=1 means data is visible the cycle after the request, matching the legacy model.
  - One request accepted per cycle. Back-to-back requests produce back-to-back valids, in order, with no bubbles.
  - No backpressure; outputs are not held.
- Data outputs hold their last value when valid=0. They do not return to 0.
- DMEM priority: when DMEM_write_i=1, DMEM_read_i is ignored that cycle and no read is enqueued.
- Writes:
  - Byte lane i is updated when DMEM_be_i[i]=1. Disabled lanes keep their old value.
  - be=4'b0000 is a legal no-op write.
  - Writes take effect at the edge they are sampled.
- Same-cycle same-word collisions are read-first:
  - An IMEM read of a word being written by DMEM returns the pre-write value.
  - A DMEM read of a word written in a previous cycle returns the new value.
- Tohost:
  - A DMEM write with the full 32-bit DMEM_addr_i[31:2] == TOHOST_ADDR[31:2] updates the array as normal.
  - It also sets tohost_o to the post-merge word (byte enables applied to the previous tohost_o value).
  - tohost_valid_o pulses for exactly one cycle. Consecutive tohost writes give consecutive pulses.
- Reset mid-operation: in-flight reads are dropped. No valid is emitted for any request issued before reset. The first valid after reset_n rises belongs to a post-reset request.
- Parameter check: at elaboration, LATENCY outside 1..8 produces $error.

Test Plan:
- Preload word 5 = 32'hDEADBEEF; IMEM_LATENCY=1; IMEM_read_n_i=0, IMEM_addr_i=0x14 at edge n -> IMEM_valid_o=1 and IMEM_data_o=32'hDEADBEEF at edge n, valid low at n+1 when the request is dropped.
- DMEM_LATENCY=3; reads of addr 0x0, 0x4, 0x8 on three consecutive cycles starting at edge n -> DMEM_valid_o high on edges n+2..n+4 with words 0, 1, 2 in order.
- Word 2 = 32'h11223344; write addr 0x8, be=4'b0101, data 32'hAABBCCDD -> subsequent read returns 32'h11BB33DD; a be=4'b0000 write leaves it unchanged.
- Same cycle: DMEM writes 32'h12345678 to 0x20 and IMEM reads 0x20 -> IMEM returns the old word; an IMEM read next cycle returns 32'h12345678.
- Write 32'h00000001 to TOHOST_ADDR with be=4'b1111 -> tohost_o=1 and tohost_valid_o high for exactly one cycle. A write to TOHOST_ADDR+(4<<ADDR_WIDTH) aliases the same array word but does not pulse tohost.
- DMEM_LATENCY=4; issue a read, then assert reset_n=0 two cycles later for one cycle -> no DMEM_valid_o for that read; array contents are intact after reset.
